// File: rtl/uart_rx_param.sv
// UART receiver: 16x oversampling with 3-sample majority vote per bit.
// Parity mode, stop-bit count and baud divisor are selectable at runtime.
module uart_rx_param #(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_en,
  input  logic [DIV_W-1:0]     baud_div,
  input  logic [1:0]           parity_mode,
  input  logic                 stop_bits,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_ferror,
  output logic                 rx_perror,
  output logic                 rx_busy
);

  localparam int BCNT_W = $clog2(DATA_BITS + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic                 sync1_q, sync1_d;
  logic                 rxs_q, rxs_d;
  logic                 rxs_prev_q, rxs_prev_d;
  logic [2:0]           state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [DIV_W-1:0]     tcnt_q, tcnt_d;
  logic [3:0]           phase_q, phase_d;
  logic [1:0]           samp_q, samp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 two_stop_q, two_stop_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 ferr_q, ferr_d;
  logic                 perr_q, perr_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_ferror_q, rx_ferror_d;
  logic                 rx_perror_q, rx_perror_d;

  logic tick, maj, start_edge, sample_now, bit_end;

  always_comb begin
    tick       = (tcnt_q == div_q);
    // phase-7 and phase-8 samples are held; the phase-9 sample is the live line
    maj        = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs_q) | (samp_q[1] & rxs_q);
    start_edge = rx_en & rxs_prev_q & ~rxs_q;
    sample_now = tick & (phase_q == 4'd9);
    bit_end    = tick & (phase_q == 4'd15);

    sync1_d     = rxd;
    rxs_d       = sync1_q;
    rxs_prev_d  = rxs_q;
    state_d     = state_q;
    div_d       = div_q;
    tcnt_d      = tick ? '0 : tcnt_q + DIV_W'(1);
    phase_d     = tick ? phase_q + 4'd1 : phase_q;
    samp_d      = samp_q;
    shift_d     = shift_q;
    bcnt_d      = bcnt_q;
    par_en_d    = par_en_q;
    par_odd_d   = par_odd_q;
    two_stop_d  = two_stop_q;
    stop_cnt_d  = stop_cnt_q;
    ferr_d      = ferr_q;
    perr_d      = perr_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_ferror_d = rx_ferror_q;
    rx_perror_d = rx_perror_q;

    if (tick && phase_q == 4'd7) samp_d[0] = rxs_q;
    if (tick && phase_q == 4'd8) samp_d[1] = rxs_q;

    if (!rx_en) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // configuration tracks the inputs until a frame starts, then freezes
          div_d      = baud_div;
          par_en_d   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
          par_odd_d  = (parity_mode == 2'b10);
          two_stop_d = stop_bits;
          tcnt_d     = '0;
          phase_d    = 4'd0;
          if (start_edge) begin
            state_d    = S_START;
            ferr_d     = 1'b0;
            perr_d     = 1'b0;
            bcnt_d     = '0;
            stop_cnt_d = 1'b0;
          end
        end
        S_START: begin
          if (sample_now && maj)  state_d = S_IDLE;
          else if (bit_end)       state_d = S_DATA;
        end
        S_DATA: begin
          if (sample_now) begin
            shift_d = {maj, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + BCNT_W'(1);
          end
          if (bit_end && bcnt_q == BCNT_W'(DATA_BITS))
            state_d = par_en_q ? S_PARITY : S_STOP;
        end
        S_PARITY: begin
          if (sample_now) perr_d = (^shift_q) ^ maj ^ par_odd_q;
          if (bit_end)    state_d = S_STOP;
        end
        S_STOP: begin
          if (sample_now) begin
            if (!maj) ferr_d = 1'b1;
            // leave at mid-bit of the final stop so the next start edge is not missed
            if (two_stop_q && !stop_cnt_q) stop_cnt_d = 1'b1;
            else                           state_d    = S_DONE;
          end
        end
        S_DONE: begin
          rx_data_d   = shift_q;
          rx_ferror_d = ferr_q;
          rx_perror_d = perr_q & par_en_q;
          rx_valid_d  = 1'b1;
          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b1;
      rxs_q       <= 1'b1;
      rxs_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      div_q       <= '0;
      tcnt_q      <= '0;
      phase_q     <= 4'd0;
      samp_q      <= 2'b11;
      shift_q     <= '0;
      bcnt_q      <= '0;
      par_en_q    <= 1'b0;
      par_odd_q   <= 1'b0;
      two_stop_q  <= 1'b0;
      stop_cnt_q  <= 1'b0;
      ferr_q      <= 1'b0;
      perr_q      <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_ferror_q <= 1'b0;
      rx_perror_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      rxs_q       <= rxs_d;
      rxs_prev_q  <= rxs_prev_d;
      state_q     <= state_d;
      div_q       <= div_d;
      tcnt_q      <= tcnt_d;
      phase_q     <= phase_d;
      samp_q      <= samp_d;
      shift_q     <= shift_d;
      bcnt_q      <= bcnt_d;
      par_en_q    <= par_en_d;
      par_odd_q   <= par_odd_d;
      two_stop_q  <= two_stop_d;
      stop_cnt_q  <= stop_cnt_d;
      ferr_q      <= ferr_d;
      perr_q      <= perr_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_ferror_q <= rx_ferror_d;
      rx_perror_q <= rx_perror_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_ferror = rx_ferror_q;
  assign rx_perror = rx_perror_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver with 16x oversampling, 3-sample majority voting, runtime-selectable parity and stop-bit modes, and a runtime baud divisor. It replaces the fixed 8N1-style receiver in the Transmitter-Receiver System. It sits between the asynchronous serial line and the consumer logic, delivering one data word per frame with a single-cycle valid strobe and per-frame error flags.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5–9, sent LSB first.
- DIV_W, 16, width of the baud divisor.
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- rx_en  in  1  receiver enable; low forces IDLE.
- baud_div  in  DIV_W  one oversample tick every baud_div+1 clk cycles. Bit period is 16*(baud_div+1) clk cycles.
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 none.
- stop_bits  in  1  0 = one stop bit, 1 = two stop bits.
- rxd  in  1  asynchronous serial input; idle high.
- rx_data  out  DATA_BITS  last received word; reset 0.
- rx_valid  out  1  one-cycle strobe, new frame complete; reset 0.
- rx_ferror  out  1  framing error of last frame; reset 0.
- rx_perror  out  1  parity error of last frame; reset 0.
- rx_busy  out  1  high in any state other than IDLE; reset 0.

## Operation
- Input sync: rxd passes through a 2-flop synchroniser. Both flops reset to 1. All logic uses the synchronised value rxs.
- Tick generator:
  - Counter runs 0..div_q and emits tick when it equals div_q.
  - In IDLE, div_q reloads from baud_div every cycle. It is frozen from the start edge until the return to IDLE.
  - On start-edge detection, the tick counter and phase counter (0..15) both clear.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- IDLE: waits for a falling edge on rxs (previous 1, current 0) with rx_en=1, then goes to START. A line stuck low after a break does not retrigger.
- Bit sampling:
  - Samples are taken at phase 7, 8 and 9. The bit value is the majority of the three.
  - Bit boundary is at phase 15 on tick; the phase then wraps to 0.
- START:
  - Majority known at phase 9. If it is 1 (false start or glitch), go to IDLE with no strobe.
  - Otherwise go to DATA at the phase-15 boundary.
- DATA:
  - Shift in DATA_BITS bits, LSB first. The bit counter width is clog2(DATA_BITS+1).
  - After the last bit, go to PARITY if parity is enabled, else to STOP.
- PARITY:
  - Even mode: error if XOR(data, parity bit) is 1.
  - Odd mode: error if XOR(data, parity bit) is 0.
- STOP:
  - A majority of 0 on any stop bit sets the internal ferror.
  - With two stop bits, both are checked.
  - Go to DONE at phase 9 of the final stop bit; there is no wait for the bit end, which allows back-to-back frames.
- DONE (one cycle):
  - Load rx_data, rx_ferror and rx_perror, and pulse rx_valid.
  - Go to IDLE.
  - rx_perror is 0 when parity is off.
  - Data is delivered even when an error flag is set.
- Outputs hold until the next DONE. Errors are per-frame and never sticky.
- rx_en low: the state goes to IDLE on the next clk. The partial frame is discarded, no rx_valid is produced, and outputs hold their values.
- reset mid-frame: all state and outputs return to reset values immediately.

## Timing
- Start-edge-to-rx_valid latency, in bit periods of B = 16*(baud_div+1) clk: (1 + DATA_BITS + P + S − 1)·B + 10·(baud_div+1) + 3 clk, ±1 tick.
  - P = 1 if parity is enabled, else 0. S = number of stop bits.
  - The +3 clk covers 2 cycles of synchroniser and 1 cycle of DONE.
- rx_valid is high for exactly one clk.
- rx_data and the flags change only in the cycle rx_valid rises.
- A falling edge one tick after DONE is accepted as the next start.

## Test plan
- 8-bit word, even parity, 1 stop, baud_div=3 (64 clk per bit). Send 0xA5 with parity bit 0 -> rx_valid once, rx_data=0xA5, ferror=0, perror=0, latency within ±4 clk of formula.
- Odd parity. Send 0x3C with parity bit 0 -> rx_data=0x3C, rx_perror=1. The next clean frame 0x01 with parity bit 0 -> perror=0.
- Stop bit driven 0 (break), 2-stop mode, 0x55 -> rx_ferror=1, rx_data=0x55. The line is then held low for 3 bit periods -> no further rx_valid until a high-then-low edge.
- Start-bit glitch of 4 ticks low -> return to IDLE, no rx_valid. A 1-tick low glitch at phase 8 of data bit 3 in 0xFF -> rx_data=0xFF.
- DATA_BITS=7, no parity. Send 0x7F then 0x00 back-to-back -> two strobes with 0x7F and 0x00. baud_div changed mid-frame -> current frame unaffected.
- rx_en dropped in DATA -> IDLE next clk, no strobe, rx_data unchanged. An async reset pulse mid-frame -> all outputs 0 and rx_busy=0 immediately.
